// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting per bit, followed by a show-ahead FIFO.
// Each FIFO entry holds {data, parity error, framing error}. Overruns are recorded in a sticky flag.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 642,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk74,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_rd,
  input  logic                 ovr_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  output logic                 rx_ovr,
  output logic                 busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] PAR     = 3'd3;
  localparam logic [2:0] STOP    = 3'd4;
  localparam logic [2:0] WAIT_HI = 3'd5;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] CNT_S0   = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] CNT_S1   = 16'(CLK_DIV / 2);
  localparam logic [15:0] CNT_S2   = 16'(CLK_DIV / 2 + 1);

  logic                 sync1_q, sync2_q, rxs_prev_q;
  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d, cnt_nxt;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           samp_q, samp_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 cnt_wrap, resolve, vote;
  logic                 frame_wr, frame_ferr;

  logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic                 ovr_q, ovr_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        head;
  logic                 empty, full, pop, push, ovr_set;

  assign rxs      = sync2_q;
  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign cnt_nxt  = cnt_wrap ? '0 : cnt_q + 16'd1;
  assign resolve  = (cnt_q == CNT_S2);
  assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

  always_comb begin
    samp_d = samp_q;
    if (cnt_q == CNT_S0) samp_d[0] = rxs;
    if (cnt_q == CNT_S1) samp_d[1] = rxs;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_nxt;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_wr   = 1'b0;
    frame_ferr = ferr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs) begin
          state_d  = START;
          bitcnt_d = '0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
        end
      end
      START: begin
        if (resolve && vote) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (resolve) begin
          shreg_d  = {vote, shreg_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end
        if (cnt_wrap && bitcnt_q == 4'(DATA_BITS)) begin
          bitcnt_d = '0;
          state_d  = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        if (resolve) perr_d = (PARITY == 1) ? ~(^shreg_q ^ vote) : (^shreg_q ^ vote);
        if (cnt_wrap) state_d = STOP;
      end
      STOP: begin
        if (resolve) begin
          frame_ferr = ferr_q | ~vote;
          ferr_d     = frame_ferr;
          if (bitcnt_q == 4'(STOP_BITS - 1)) begin
            frame_wr = 1'b1;
            state_d  = frame_ferr ? WAIT_HI : IDLE;
            cnt_d    = '0;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // On a full FIFO, a simultaneous pop frees the slot that the incoming write reuses.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop     = rx_rd & ~empty;
    push    = frame_wr & (~full | pop);
    ovr_set = frame_wr & full & ~pop;
    wptr_d  = wptr_q + (AW+1)'(push);
    rptr_d  = rptr_q + (AW+1)'(pop);
    ovr_d   = ovr_set | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge clk74 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      samp_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      samp_q     <= samp_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ovr_q      <= ovr_d;
    end
  end

  always_ff @(posedge clk74) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {shreg_q, perr_q, frame_ferr};
  end

  assign head                        = mem_q[rptr_q[AW-1:0]];
  assign {rx_data, rx_perr, rx_ferr} = empty ? '0 : head;
  assign rx_valid                    = ~empty;
  assign rx_ovr                      = ovr_q;
  assign busy                        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, both with CLK_DIV=16.
// Expected FIFO entries are queued when each frame is sent and compared as entries are popped.
module tb_uart_rx_fifo;

  localparam int DIV = 16;

  logic       clk74 = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_a = 1'b1, rx_p = 1'b1;
  logic       rd_a = 1'b0, rd_p = 1'b0;
  logic       ovr_clr_a = 1'b0, ovr_clr_p = 1'b0;
  logic [7:0] rx_data_a, rx_data_p;
  logic       rx_perr_a, rx_ferr_a, rx_valid_a, rx_ovr_a, busy_a;
  logic       rx_perr_p, rx_ferr_p, rx_valid_p, rx_ovr_p, busy_p;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [9:0] sb_a[$];
  logic [9:0] sb_p[$];

  always #5 clk74 = ~clk74;

  uart_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk74(clk74), .reset_n(reset_n), .rx(rx_a), .rx_rd(rd_a), .ovr_clr(ovr_clr_a),
    .rx_data(rx_data_a), .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a),
    .rx_valid(rx_valid_a), .rx_ovr(rx_ovr_a), .busy(busy_a)
  );

  uart_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .clk74(clk74), .reset_n(reset_n), .rx(rx_p), .rx_rd(rd_p), .ovr_clr(ovr_clr_p),
    .rx_data(rx_data_p), .rx_perr(rx_perr_p), .rx_ferr(rx_ferr_p),
    .rx_valid(rx_valid_p), .rx_ovr(rx_ovr_p), .busy(busy_p)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One bit period on the selected line; glitch inverts a single clock mid-bit.
  task automatic drive_bit(input bit sel, input logic v, input bit glitch);
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk74);
      if (sel) rx_p = (glitch && i == DIV/2) ? ~v : v;
      else     rx_a = (glitch && i == DIV/2) ? ~v : v;
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit,
                            input logic stop, input int gbit);
    drive_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], i == gbit);
    if (sel) drive_bit(sel, pbit, 1'b0);
    drive_bit(sel, stop, 1'b0);
    if (stop) drive_bit(sel, 1'b1, 1'b0);
  endtask

  task automatic drain(input bit sel, input string tag);
    logic [9:0] exp;
    while ((sel ? sb_p.size() : sb_a.size()) > 0) begin
      if (sel) begin
        exp = sb_p.pop_front();
        chk({tag, "_valid"}, 32'(rx_valid_p), 32'd1);
        chk({tag, "_data"},  32'(rx_data_p),  32'(exp[9:2]));
        chk({tag, "_perr"},  32'(rx_perr_p),  32'(exp[1]));
        chk({tag, "_ferr"},  32'(rx_ferr_p),  32'(exp[0]));
        rd_p = 1'b1;
      end else begin
        exp = sb_a.pop_front();
        chk({tag, "_valid"}, 32'(rx_valid_a), 32'd1);
        chk({tag, "_data"},  32'(rx_data_a),  32'(exp[9:2]));
        chk({tag, "_perr"},  32'(rx_perr_a),  32'(exp[1]));
        chk({tag, "_ferr"},  32'(rx_ferr_a),  32'(exp[0]));
        rd_a = 1'b1;
      end
      @(negedge clk74);
      rd_a = 1'b0;
      rd_p = 1'b0;
    end
    chk({tag, "_empty"}, 32'(sel ? rx_valid_p : rx_valid_a), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk74);
    chk("rst_valid", 32'(rx_valid_a), 32'd0);
    chk("rst_busy",  32'(busy_a),     32'd0);
    chk("rst_data",  32'(rx_data_a),  32'd0);
    chk("rst_ovr",   32'(rx_ovr_a),   32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk74);

    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
    sb_a.push_back({8'hA5, 1'b0, 1'b0});
    chk("a5_busy", 32'(busy_a), 32'd0);
    drain(1'b0, "a5");

    @(negedge clk74) rx_a = 1'b0;
    repeat (4) @(negedge clk74);
    rx_a = 1'b1;
    repeat (3 * DIV) @(negedge clk74);
    chk("fstart_valid", 32'(rx_valid_a), 32'd0);
    chk("fstart_busy",  32'(busy_a),     32'd0);

    send_frame(1'b1, 8'h03, 1'b1, 1'b1, -1);
    sb_p.push_back({8'h03, 1'b1, 1'b0});
    send_frame(1'b1, 8'h03, 1'b0, 1'b1, -1);
    sb_p.push_back({8'h03, 1'b0, 1'b0});
    drain(1'b1, "par");

    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, -1);
    repeat (100 * DIV) @(negedge clk74);
    chk("brk_busy", 32'(busy_a), 32'd1);
    rx_a = 1'b1;
    repeat (2 * DIV) @(negedge clk74);
    sb_a.push_back({8'h3C, 1'b0, 1'b1});
    send_frame(1'b0, 8'h55, 1'b0, 1'b1, -1);
    sb_a.push_back({8'h55, 1'b0, 1'b0});
    drain(1'b0, "brk");

    send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 3);
    sb_a.push_back({8'h5A, 1'b0, 1'b0});
    drain(1'b0, "glitch");

    for (int i = 1; i <= 5; i++) begin
      send_frame(1'b0, 8'(i), 1'b0, 1'b1, -1);
      if (i <= 4) sb_a.push_back({8'(i), 1'b0, 1'b0});
    end
    chk("ovr_set", 32'(rx_ovr_a), 32'd1);
    drain(1'b0, "ovr");
    chk("ovr_sticky", 32'(rx_ovr_a), 32'd1);
    ovr_clr_a = 1'b1;
    @(negedge clk74);
    ovr_clr_a = 1'b0;
    chk("ovr_clr", 32'(rx_ovr_a), 32'd0);

    // Leave one entry queued, then reset in the middle of the next frame.
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, -1);
    chk("pre_rst_valid", 32'(rx_valid_a), 32'd1);
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0);
    chk("mid_rst_valid", 32'(rx_valid_a), 32'd0);
    chk("mid_rst_busy",  32'(busy_a),     32'd0);
    chk("mid_rst_data",  32'(rx_data_a),  32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b1, 1'b0);
    chk("post_rst_valid", 32'(rx_valid_a), 32'd0);
    chk("post_rst_busy",  32'(busy_a),     32'd0);

    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
    sb_a.push_back({8'hA5, 1'b0, 1'b0});
    drain(1'b0, "recov");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
